psum_pool_manager: RTL and testbench

Parametrised successor to the single-stream partial-sum manager. It keeps a pool of NUM_SMALL_BANKS small and NUM_BIG_BANKS big psum banks, allocates one bank per accepted operation and runs several operations at once. A round-robin arbiter drives the shared accumulator read/write port for all active operations. It reports per-operation completion and rejects illegal requests.

---
 rtl/psum_pool_manager_if.sv | 42 ++++
 rtl/psum_pool_manager.sv | 236 +++++++++++++++++++++++
 tb/tb_psum_pool_manager.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_pool_manager_if.sv
// Bundle of request, accumulator-port and status signals between the psum pool
// manager (slave) and the requester/datapath side (master).
interface psum_pool_manager_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int OP_ID_WIDTH = 8,
  parameter int SEQ2_WIDTH  = 16,
  parameter int NB          = 4
);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_WIDTH-1:0]  seq1;
  logic [SEQ2_WIDTH-1:0]  seq2;
  logic [OP_ID_WIDTH-1:0] operation_id;
  logic                   stall;
  logic                   req_err;
  logic [OP_ID_WIDTH-1:0] req_err_id;
  logic                   mac_ready;
  logic                   rd_valid;
  logic [BW-1:0]          rd_bank;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic                   first_pass;
  logic                   wr_valid;
  logic [BW-1:0]          wr_bank;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic                   op_done;
  logic [OP_ID_WIDTH-1:0] op_done_id;
  logic [NB-1:0]          busy_mask;

  modport master (
    output req_valid, seq1, seq2, operation_id, mac_ready,
    input  req_ready, stall, req_err, req_err_id, rd_valid, rd_bank, rd_addr,
           first_pass, wr_valid, wr_bank, wr_addr, op_done, op_done_id, busy_mask
  );

  modport slave (
    input  req_valid, seq1, seq2, operation_id, mac_ready,
    output req_ready, stall, req_err, req_err_id, rd_valid, rd_bank, rd_addr,
           first_pass, wr_valid, wr_bank, wr_addr, op_done, op_done_id, busy_mask
  );
endinterface

// File: rtl/psum_pool_manager.sv
// Pool of small/big psum banks: allocates one bank per operation and round-robin
// shares the accumulator read/write port among all active operations.
module psum_pool_manager #(
  parameter int ADDR_WIDTH      = 8,
  parameter int OP_ID_WIDTH     = 8,
  parameter int SEQ2_WIDTH      = 16,
  parameter int NUM_SMALL_BANKS = 2,
  parameter int NUM_BIG_BANKS   = 2,
  parameter int SMALL_DEPTH     = 16,
  parameter int BIG_DEPTH       = 255,
  parameter int SPILL_EN        = 1
) (
  input logic               clk,
  input logic               reset,
  psum_pool_manager_if.slave bus
);
  localparam int NB = NUM_SMALL_BANKS + NUM_BIG_BANKS;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [ADDR_WIDTH-1:0] SMALL_LIM = ADDR_WIDTH'(SMALL_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BIG_LIM   = ADDR_WIDTH'(BIG_DEPTH);
  localparam logic [BW-1:0]         LAST_BANK = BW'(NB - 1);

  logic [NB-1:0]          r_busy;
  logic [NB-1:0]          r_drain;
  logic [OP_ID_WIDTH-1:0] r_tag    [NB];
  logic [ADDR_WIDTH-1:0]  r_len    [NB];
  logic [ADDR_WIDTH-1:0]  r_addr   [NB];
  logic [SEQ2_WIDTH-1:0]  r_passes [NB];
  logic [SEQ2_WIDTH-1:0]  r_pass   [NB];
  logic [BW-1:0]          r_ptr;
  logic                   r_wr_valid;
  logic [BW-1:0]          r_wr_bank;
  logic [ADDR_WIDTH-1:0]  r_wr_addr;
  logic                   r_done;
  logic [OP_ID_WIDTH-1:0] r_done_id;
  logic                   r_req_err;
  logic [OP_ID_WIDTH-1:0] r_req_err_id;

  logic                   w_illegal;
  logic                   w_small_req;
  logic                   w_small_found;
  logic [BW-1:0]          w_small_idx;
  logic                   w_big_found;
  logic [BW-1:0]          w_big_idx;
  logic                   w_alloc_ok;
  logic [BW-1:0]          w_alloc_idx;
  logic                   w_req_ready;
  logic                   w_accept;
  logic                   w_alloc;
  logic                   w_reject;
  logic [NB-1:0]          w_elig;
  logic                   w_grant;
  logic [BW-1:0]          w_gidx;
  logic [ADDR_WIDTH-1:0]  w_rd_addr;
  logic                   w_first;
  logic                   w_addr_last;
  logic                   w_pass_last;
  logic                   w_final;
  logic [BW-1:0]          w_next_ptr;
  int                     v_j;

  // Request legality and size class.
  always_comb begin
    w_illegal   = (bus.seq1 == {ADDR_WIDTH{1'b0}}) || (bus.seq1 > BIG_LIM) ||
                  (bus.seq2 == {SEQ2_WIDTH{1'b0}});
    w_small_req = (bus.seq1 <= SMALL_LIM);
  end

  // Lowest-index free bank within each class, from the registered busy mask.
  always_comb begin
    w_small_found = 1'b0;
    w_small_idx   = {BW{1'b0}};
    w_big_found   = 1'b0;
    w_big_idx     = {BW{1'b0}};
    for (int i = 0; i < NUM_SMALL_BANKS; i++) begin
      if (!w_small_found && !r_busy[i]) begin
        w_small_found = 1'b1;
        w_small_idx   = BW'(i);
      end else begin
        w_small_found = w_small_found;
      end
    end
    for (int i = NUM_SMALL_BANKS; i < NB; i++) begin
      if (!w_big_found && !r_busy[i]) begin
        w_big_found = 1'b1;
        w_big_idx   = BW'(i);
      end else begin
        w_big_found = w_big_found;
      end
    end
  end

  // Bank choice for a legal request, with optional spill of small ops into big banks.
  always_comb begin
    w_alloc_ok  = 1'b0;
    w_alloc_idx = {BW{1'b0}};
    if (w_illegal) begin
      w_alloc_ok = 1'b0;
    end else if (w_small_req && w_small_found) begin
      w_alloc_ok  = 1'b1;
      w_alloc_idx = w_small_idx;
    end else if (w_small_req && (SPILL_EN != 0) && w_big_found) begin
      w_alloc_ok  = 1'b1;
      w_alloc_idx = w_big_idx;
    end else if (!w_small_req && w_big_found) begin
      w_alloc_ok  = 1'b1;
      w_alloc_idx = w_big_idx;
    end else begin
      w_alloc_ok = 1'b0;
    end
  end

  // Illegal requests are always taken so they can be reported.
  always_comb begin
    w_req_ready = !reset && (w_illegal || w_alloc_ok);
    w_accept    = bus.req_valid && w_req_ready;
    w_alloc     = w_accept && !w_illegal;
    w_reject    = w_accept && w_illegal;
  end

  // Round-robin grant over busy, non-draining banks starting at the pointer.
  always_comb begin
    w_elig  = r_busy & ~r_drain;
    w_grant = 1'b0;
    w_gidx  = {BW{1'b0}};
    v_j     = 0;
    if (bus.mac_ready && !reset) begin
      for (int k = 0; k < NB; k++) begin
        v_j = int'(r_ptr) + k;
        if (v_j >= NB) begin
          v_j = v_j - NB;
        end else begin
          v_j = v_j;
        end
        if (!w_grant && w_elig[v_j]) begin
          w_grant = 1'b1;
          w_gidx  = BW'(v_j);
        end else begin
          w_grant = w_grant;
        end
      end
    end else begin
      w_grant = 1'b0;
    end
  end

  // Read-side attributes of the granted access.
  always_comb begin
    w_addr_last = (r_addr[w_gidx] == r_len[w_gidx] - ADDR_WIDTH'(1));
    w_pass_last = (r_pass[w_gidx] == r_passes[w_gidx] - SEQ2_WIDTH'(1));
    w_next_ptr  = (w_gidx == LAST_BANK) ? {BW{1'b0}} : w_gidx + BW'(1);
    if (w_grant) begin
      w_rd_addr = r_addr[w_gidx];
      w_first   = (r_pass[w_gidx] == {SEQ2_WIDTH{1'b0}});
      w_final   = w_addr_last && w_pass_last;
    end else begin
      w_rd_addr = {ADDR_WIDTH{1'b0}};
      w_first   = 1'b0;
      w_final   = 1'b0;
    end
  end

  // Pipeline, status and per-bank state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy       <= {NB{1'b0}};
      r_drain      <= {NB{1'b0}};
      r_ptr        <= {BW{1'b0}};
      r_wr_valid   <= 1'b0;
      r_wr_bank    <= {BW{1'b0}};
      r_wr_addr    <= {ADDR_WIDTH{1'b0}};
      r_done       <= 1'b0;
      r_done_id    <= {OP_ID_WIDTH{1'b0}};
      r_req_err    <= 1'b0;
      r_req_err_id <= {OP_ID_WIDTH{1'b0}};
      for (int i = 0; i < NB; i++) begin
        r_tag[i]    <= {OP_ID_WIDTH{1'b0}};
        r_len[i]    <= {ADDR_WIDTH{1'b0}};
        r_addr[i]   <= {ADDR_WIDTH{1'b0}};
        r_passes[i] <= {SEQ2_WIDTH{1'b0}};
        r_pass[i]   <= {SEQ2_WIDTH{1'b0}};
      end
    end else begin
      r_wr_valid   <= w_grant;
      r_wr_bank    <= w_gidx;
      r_wr_addr    <= w_rd_addr;
      r_done       <= w_final;
      r_done_id    <= w_final ? r_tag[w_gidx] : {OP_ID_WIDTH{1'b0}};
      r_req_err    <= w_reject;
      r_req_err_id <= w_reject ? bus.operation_id : {OP_ID_WIDTH{1'b0}};
      if (w_grant) begin
        r_ptr <= w_next_ptr;
      end
      // A bank being freed is still busy in the mask seen by this cycle's request.
      for (int i = 0; i < NB; i++) begin
        if (w_alloc && (w_alloc_idx == BW'(i))) begin
          r_busy[i]   <= 1'b1;
          r_drain[i]  <= 1'b0;
          r_tag[i]    <= bus.operation_id;
          r_len[i]    <= bus.seq1;
          r_passes[i] <= bus.seq2;
          r_addr[i]   <= {ADDR_WIDTH{1'b0}};
          r_pass[i]   <= {SEQ2_WIDTH{1'b0}};
        end else if (r_done && (r_wr_bank == BW'(i))) begin
          r_busy[i]  <= 1'b0;
          r_drain[i] <= 1'b0;
        end else if (w_grant && (w_gidx == BW'(i))) begin
          if (w_final) begin
            r_drain[i] <= 1'b1;
          end
          if (w_addr_last) begin
            r_addr[i] <= {ADDR_WIDTH{1'b0}};
            r_pass[i] <= r_pass[i] + SEQ2_WIDTH'(1);
          end else begin
            r_addr[i] <= r_addr[i] + ADDR_WIDTH'(1);
          end
        end
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.stall      = bus.req_valid && !w_req_ready && !reset;
  assign bus.req_err    = r_req_err;
  assign bus.req_err_id = r_req_err_id;
  assign bus.rd_valid   = w_grant;
  assign bus.rd_bank    = w_gidx;
  assign bus.rd_addr    = w_rd_addr;
  assign bus.first_pass = w_first;
  assign bus.wr_valid   = r_wr_valid;
  assign bus.wr_bank    = r_wr_bank;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.op_done    = r_done;
  assign bus.op_done_id = r_done_id;
  assign bus.busy_mask  = r_busy;
endmodule

// File: tb/tb_psum_pool_manager.sv
// Bench for psum_pool_manager: a spill-enabled and a spill-disabled instance
// share request data and are both checked every cycle against a reference model.
module tb_psum_pool_manager;
  localparam int AW = 9;
  localparam int IW = 8;
  localparam int SW = 16;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic va = 1'b0, vb = 1'b0, mac = 1'b0;
  logic [AW-1:0] s1 = '0;
  logic [SW-1:0] s2 = '0;
  logic [IW-1:0] oid = '0;
  bit chk_en = 1'b0;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  psum_pool_manager_if #(.ADDR_WIDTH(AW), .OP_ID_WIDTH(IW), .SEQ2_WIDTH(SW), .NB(NB)) bus_a ();
  psum_pool_manager_if #(.ADDR_WIDTH(AW), .OP_ID_WIDTH(IW), .SEQ2_WIDTH(SW), .NB(NB)) bus_b ();

  assign bus_a.req_valid = va;
  assign bus_a.seq1 = s1;
  assign bus_a.seq2 = s2;
  assign bus_a.operation_id = oid;
  assign bus_a.mac_ready = mac;
  assign bus_b.req_valid = vb;
  assign bus_b.seq1 = s1;
  assign bus_b.seq2 = s2;
  assign bus_b.operation_id = oid;
  assign bus_b.mac_ready = mac;

  psum_pool_manager #(.ADDR_WIDTH(AW), .OP_ID_WIDTH(IW), .SEQ2_WIDTH(SW), .NUM_SMALL_BANKS(2),
    .NUM_BIG_BANKS(2), .SMALL_DEPTH(16), .BIG_DEPTH(255), .SPILL_EN(1))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  psum_pool_manager #(.ADDR_WIDTH(AW), .OP_ID_WIDTH(IW), .SEQ2_WIDTH(SW), .NUM_SMALL_BANKS(2),
    .NUM_BIG_BANKS(2), .SMALL_DEPTH(16), .BIG_DEPTH(255), .SPILL_EN(0))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // Reference model: each bank holds the number of accesses already granted (k);
  // the access address is k mod len and the bank is exhausted at k == len*passes.
  bit mbusy [2][NB];
  int mtag [2][NB], mlen [2][NB], mpas [2][NB], mk [2][NB];
  int mptr [2];
  bit mwv [2], mdn [2], merr [2];
  int mwb [2], mwa [2], mdid [2], meid [2];
  int mg, mb;
  bit mlg, mrdy;

  function automatic bit m_legal();
    return (s1 != 0) && (s1 <= 255) && (s2 != 0);
  endfunction

  function automatic int m_alloc(int m);
    int lo = (s1 <= 16) ? 0 : 2;
    int hi = (s1 <= 16 && m == 0) ? NB : ((s1 <= 16) ? 2 : NB);
    for (int i = lo; i < hi; i++)
      if (!mbusy[m][i]) return i;
    return -1;
  endfunction

  function automatic int m_grant(int m);
    if (reset || !mac) return -1;
    for (int k = 0; k < NB; k++) begin
      int j = (mptr[m] + k) % NB;
      if (mbusy[m][j] && mk[m][j] < mlen[m][j] * mpas[m][j]) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int m, input logic rdy, input logic stl, input logic er,
                     input logic [IW-1:0] eid, input logic rv, input logic [1:0] rb,
                     input logic [AW-1:0] ra, input logic fp, input logic wv,
                     input logic [1:0] wb, input logic [AW-1:0] wa, input logic dn,
                     input logic [IW-1:0] did, input logic [NB-1:0] mask);
    string p = (m == 0) ? "A" : "B";
    bit lg = m_legal();
    bit er_rdy = !reset && (!lg || m_alloc(m) >= 0);
    bit vld = (m == 0) ? va : vb;
    int g = m_grant(m);
    int emask = 0;
    for (int i = 0; i < NB; i++) emask |= (mbusy[m][i] ? 1 : 0) << i;
    chk({p, " req_ready"}, rdy, er_rdy);
    chk({p, " stall"}, stl, !reset && vld && !er_rdy);
    chk({p, " req_err"}, er, merr[m]);
    chk({p, " req_err_id"}, eid, meid[m]);
    chk({p, " rd_valid"}, rv, g >= 0);
    chk({p, " rd_bank"}, rb, (g >= 0) ? g : 0);
    chk({p, " rd_addr"}, ra, (g >= 0) ? mk[m][g] % mlen[m][g] : 0);
    chk({p, " first_pass"}, fp, (g >= 0) && (mk[m][g] < mlen[m][g]));
    chk({p, " wr_valid"}, wv, mwv[m]);
    chk({p, " wr_bank"}, wb, mwb[m]);
    chk({p, " wr_addr"}, wa, mwa[m]);
    chk({p, " op_done"}, dn, mdn[m]);
    chk({p, " op_done_id"}, did, mdid[m]);
    chk({p, " busy_mask"}, mask, emask);
  endtask

  // Model state advance on each active edge.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        for (int i = 0; i < NB; i++) begin
          mbusy[m][i] = 0; mtag[m][i] = 0; mlen[m][i] = 0; mpas[m][i] = 0; mk[m][i] = 0;
        end
        mptr[m] = 0; mwv[m] = 0; mdn[m] = 0; merr[m] = 0;
        mwb[m] = 0; mwa[m] = 0; mdid[m] = 0; meid[m] = 0;
      end else begin
        mlg = m_legal();
        mb = mlg ? m_alloc(m) : -1;
        mrdy = !mlg || (mb >= 0);
        mg = m_grant(m);
        if (mdn[m]) mbusy[m][mwb[m]] = 0;
        if (mg >= 0) begin
          mwv[m] = 1; mwb[m] = mg; mwa[m] = mk[m][mg] % mlen[m][mg];
          mdn[m] = (mk[m][mg] + 1 == mlen[m][mg] * mpas[m][mg]);
          mdid[m] = mdn[m] ? mtag[m][mg] : 0;
          mk[m][mg]++;
          mptr[m] = (mg + 1) % NB;
        end else begin
          mwv[m] = 0; mwb[m] = 0; mwa[m] = 0; mdn[m] = 0; mdid[m] = 0;
        end
        merr[m] = 0; meid[m] = 0;
        if (((m == 0) ? va : vb) && mrdy) begin
          if (!mlg) begin
            merr[m] = 1; meid[m] = oid;
          end else begin
            mbusy[m][mb] = 1; mtag[m][mb] = oid; mlen[m][mb] = s1; mpas[m][mb] = s2; mk[m][mb] = 0;
          end
        end
      end
    end
  end

  // Compare both instances against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, bus_a.req_ready, bus_a.stall, bus_a.req_err, bus_a.req_err_id, bus_a.rd_valid,
          bus_a.rd_bank, bus_a.rd_addr, bus_a.first_pass, bus_a.wr_valid, bus_a.wr_bank,
          bus_a.wr_addr, bus_a.op_done, bus_a.op_done_id, bus_a.busy_mask);
      cmp(1, bus_b.req_ready, bus_b.stall, bus_b.req_err, bus_b.req_err_id, bus_b.rd_valid,
          bus_b.rd_bank, bus_b.rd_addr, bus_b.first_pass, bus_b.wr_valid, bus_b.wr_bank,
          bus_b.wr_addr, bus_b.op_done, bus_b.op_done_id, bus_b.busy_mask);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; va = 1'b0; vb = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic req(input int a, input int b, input int id);
    s1 = AW'(a); s2 = SW'(b); oid = IW'(id); va = 1'b1; vb = 1'b1;
  endtask

  typedef struct {
    int s1; int s2; int id;
    bit rdy_a; bit rdy_b; int mask_a; int mask_b; bit err;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int nrd, bad, first_c, last_c, done_c, done_id, acc_c, ndone;
    tbl[0] = '{8,   3, 8'h01, 1, 1, 4'b0001, 4'b0001, 0};
    tbl[1] = '{0,   3, 8'h02, 1, 1, 4'b0001, 4'b0001, 1};
    tbl[2] = '{20,  2, 8'h03, 1, 1, 4'b0101, 4'b0101, 0};
    tbl[3] = '{16,  1, 8'h04, 1, 1, 4'b0111, 4'b0111, 0};
    tbl[4] = '{300, 1, 8'h05, 1, 1, 4'b0111, 4'b0111, 1};
    tbl[5] = '{255, 0, 8'h06, 1, 1, 4'b0111, 4'b0111, 1};
    tbl[6] = '{4,   1, 8'h07, 1, 0, 4'b1111, 4'b0111, 0};
    tbl[7] = '{255, 1, 8'h08, 0, 1, 4'b1111, 4'b1111, 0};
    tbl[8] = '{17,  1, 8'h09, 0, 0, 4'b1111, 4'b1111, 0};
    tbl[9] = '{256, 1, 8'h0A, 1, 1, 4'b1111, 4'b1111, 1};

    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // Allocation and legality table with the port stalled so banks stay held.
    mac = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req(tbl[i].s1, tbl[i].s2, tbl[i].id);
      #1;
      chk($sformatf("tbl%0d rdy A", i), bus_a.req_ready, tbl[i].rdy_a);
      chk($sformatf("tbl%0d rdy B", i), bus_b.req_ready, tbl[i].rdy_b);
      tick();
      va = 1'b0; vb = 1'b0;
      chk($sformatf("tbl%0d mask A", i), bus_a.busy_mask, tbl[i].mask_a);
      chk($sformatf("tbl%0d mask B", i), bus_b.busy_mask, tbl[i].mask_b);
      chk($sformatf("tbl%0d err A", i), bus_a.req_err, tbl[i].err);
      chk($sformatf("tbl%0d err B", i), bus_b.req_err, tbl[i].err);
      chk($sformatf("tbl%0d err_id A", i), bus_a.req_err_id, tbl[i].err ? tbl[i].id : 0);
      tick();
    end

    // Single op 8x3: reads in the 24 cycles after acceptance, done one cycle later.
    do_reset();
    mac = 1'b1;
    req(8, 3, 8'h01);
    tick();
    va = 1'b0; vb = 1'b0;
    nrd = 0; bad = 0; first_c = -1; last_c = -1; done_c = -1; done_id = -1;
    for (int c = 1; c <= 26; c++) begin
      if (bus_a.rd_valid) begin
        if (bus_a.rd_addr != AW'(nrd % 8) || bus_a.rd_bank != 2'd0 ||
            bus_a.first_pass != (nrd < 8)) bad++;
        nrd++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      if (bus_a.op_done) begin done_c = c; done_id = bus_a.op_done_id; end
      if (c == 26) chk("t1 mask freed", bus_a.busy_mask, 4'b0000);
      tick();
    end
    chk("t1 rd count", nrd, 24);
    chk("t1 rd pattern", bad, 0);
    chk("t1 first rd", first_c, 1);
    chk("t1 last rd", last_c, 24);
    chk("t1 done cycle", done_c, 25);
    chk("t1 done id", done_id, 8'h01);

    // Small banks full: A spills at once, B waits until the cycle after a free.
    do_reset();
    mac = 1'b1;
    req(4, 2, 8'h10);
    tick();
    req(16, 20, 8'h11);
    tick();
    req(5, 1, 8'h12);
    #1;
    chk("t4 A ready", bus_a.req_ready, 1'b1);
    chk("t4 B stall", bus_b.stall, 1'b1);
    tick();
    va = 1'b0;
    chk("t4 A spill mask", bus_a.busy_mask, 4'b0111);
    done_c = -1; acc_c = -1;
    for (int c = 0; c < 200; c++) begin
      if (bus_b.op_done && bus_b.op_done_id == 8'h10) done_c = c;
      if (bus_b.req_ready) begin acc_c = c; break; end
      tick();
    end
    chk("t4 B accepted", acc_c >= 0, 1'b1);
    chk("t4 B accept after free", acc_c, done_c + 1);
    tick();
    vb = 1'b0;
    chk("t4 B mask", bus_b.busy_mask, 4'b0011);

    // Port stall freezes the op; then a reset drops it silently.
    do_reset();
    mac = 1'b1;
    req(8, 2, 8'h20);
    tick();
    va = 1'b0; vb = 1'b0;
    tick(); tick(); tick();
    mac = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t6 frozen rd", bus_a.rd_valid, 1'b0);
      tick();
    end
    mac = 1'b1;
    #1;
    chk("t6 resume rd", bus_a.rd_valid, 1'b1);
    chk("t6 resume addr", bus_a.rd_addr, 9'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6 rst rd", bus_a.rd_valid, 1'b0);
    chk("t6 rst wr", bus_a.wr_valid, 1'b0);
    chk("t6 rst mask", bus_a.busy_mask, 4'b0000);
    chk("t6 rst done", bus_a.op_done, 1'b0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus_a.op_done || bus_b.op_done) ndone++;
      tick();
    end
    chk("t6 no done after reset", ndone, 0);

    // Random traffic, every cycle checked against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int r = $urandom_range(99);
      va = ($urandom_range(2) == 0);
      vb = ($urandom_range(2) == 0);
      mac = ($urandom_range(4) != 0);
      if (r < 5) s1 = 9'd0;
      else if (r < 10) s1 = AW'($urandom_range(511, 256));
      else if (r < 15) s1 = AW'($urandom_range(255, 200));
      else s1 = AW'($urandom_range(40, 1));
      s2 = ($urandom_range(19) == 0) ? 16'd0 : SW'($urandom_range(3, 1));
      oid = IW'($urandom);
      reset = ($urandom_range(599) == 0);
      tick();
    end
    va = 1'b0; vb = 1'b0; reset = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
